rf_port_master: RTL and testbench

//  Command-side initiator for the 8x4b register file. Accepts one command per

---
 rtl/rf_master_pkg.sv | 21 ++
 rtl/rf_op_alu.sv | 60 ++++++
 rtl/rf_port_master.sv | 161 ++++++++++++++++
 tb/tb_rf_port_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_master_pkg.sv
// rtl/rf_master_pkg.sv - shared types and defaults for the register-file port master
package rf_master_pkg;

    localparam int RF_AW = 3;
    localparam int RF_DW = 4;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ADD   = 2'b10,
        OP_XOR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_RESP  = 2'b10,
        ST_SCRUB = 2'b11
    } state_e;

endpackage

// File: rtl/rf_op_alu.sv
// rtl/rf_op_alu.sv - combinational read-modify-write operation unit
//
// Ports:
//   op      in   latched command opcode
//   old_val in   current register contents (RF combinational read)
//   data    in   command operand
//   wr_val  out  value to write back
//   wr_en   out  write-back required (all ops except READ)
//   result  out  response data
//   carry   out  ADD carry-out, 0 otherwise
module rf_op_alu
    import rf_master_pkg::*;
#(
    parameter int DW = RF_DW
) (
    input  op_e           op,
    input  logic [DW-1:0] old_val,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] wr_val,
    output logic          wr_en,
    output logic [DW-1:0] result,
    output logic          carry
);

    logic [DW:0] sum;

    always_comb begin
        sum    = {1'b0, old_val} + {1'b0, data};
        wr_val = old_val;
        wr_en  = 1'b0;
        result = old_val;
        carry  = 1'b0;
        case (op)
            OP_READ: begin
                result = old_val;
            end
            OP_WRITE: begin
                // Response returns the contents being overwritten.
                wr_val = data;
                wr_en  = 1'b1;
                result = old_val;
            end
            OP_ADD: begin
                wr_val = sum[DW-1:0];
                wr_en  = 1'b1;
                result = sum[DW-1:0];
                carry  = sum[DW];
            end
            OP_XOR: begin
                wr_val = old_val ^ data;
                wr_en  = 1'b1;
                result = old_val ^ data;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rf_port_master.sv
// rtl/rf_port_master.sv - command-side initiator for the register file (READ/WRITE/ADD/XOR)
//
// Optional feature: define RF_SCRUB_EN to zero every RF entry after reset.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op/cmd_addr/cmd_data      command fields
//   rsp_valid/rsp_ready           response handshake
//   rsp_data/rsp_carry            response result and ADD carry
//   rf_wr_addr/rf_wr_val/rf_wr_en RF write port
//   rf_rd_addr/rf_rd_val          RF combinational read port
//   busy                          state is not IDLE
module rf_port_master
    import rf_master_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_carry,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_val,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_rd_addr,
    input  logic [DW-1:0] rf_rd_val,
    output logic          busy
);

    localparam int NREG = 2 ** AW;

    state_e        state;
    state_e        state_nxt;
    op_e           lat_op;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_carry_q;

    logic [DW-1:0] alu_wr_val;
    logic          alu_wr_en;
    logic [DW-1:0] alu_result;
    logic          alu_carry;

`ifdef RF_SCRUB_EN
    logic [AW-1:0] scrub_idx;
`endif

    rf_op_alu #(.DW(DW)) u_alu (
        .op      (lat_op),
        .old_val (rf_rd_val),
        .data    (lat_data),
        .wr_val  (alu_wr_val),
        .wr_en   (alu_wr_en),
        .result  (alu_result),
        .carry   (alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef RF_SCRUB_EN
            state <= ST_SCRUB;
`else
            state <= ST_IDLE;
`endif
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_op      <= OP_READ;
            lat_addr    <= '0;
            lat_data    <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                lat_op   <= op_e'(cmd_op);
                lat_addr <= cmd_addr;
                lat_data <= cmd_data;
            end
            if (state == ST_EXEC) begin
                rsp_data_q  <= alu_result;
                rsp_carry_q <= alu_carry;
            end
        end
    end

`ifdef RF_SCRUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scrub_idx <= '0;
        end else if (state == ST_SCRUB) begin
            scrub_idx <= scrub_idx + 1'b1;
        end
    end
`endif

    assign rf_rd_addr = lat_addr;
    assign rsp_data   = rsp_data_q;
    assign rsp_carry  = rsp_carry_q;

    // Handshake and write strobes are qualified with rst_n so every output
    // is 0 while reset is held, even though the reset state of a scrubbing
    // build is SCRUB rather than IDLE.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rf_wr_en   = 1'b0;
        rf_wr_addr = lat_addr;
        rf_wr_val  = '0;
        busy       = rst_n && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rf_wr_en  = alu_wr_en;
                rf_wr_val = alu_wr_val;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SCRUB: begin
`ifdef RF_SCRUB_EN
                rf_wr_en   = rst_n;
                rf_wr_addr = scrub_idx;
                rf_wr_val  = '0;
                if (scrub_idx == AW'(NREG - 1)) begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_port_master.sv
// tb/tb_rf_port_master.sv - self-checking bench for rf_port_master
module tb_rf_port_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic [2:0] rf_wr_addr;
    logic [3:0] rf_wr_val;
    logic       rf_wr_en;
    logic [2:0] rf_rd_addr;
    logic [3:0] rf_rd_val;
    logic       busy;

    always #5 clk = ~clk;

    rf_port_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_val  (rf_wr_val),
        .rf_wr_en   (rf_wr_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_val  (rf_rd_val),
        .busy       (busy)
    );

    // Register file seen by the DUT: synchronous write, combinational read.
    logic [3:0] rf [8];
    logic       preload;
    logic [3:0] preload_val;

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 8; k++) rf[k] <= preload_val;
        end else if (rf_wr_en) begin
            rf[rf_wr_addr] <= rf_wr_val;
        end
    end
    assign rf_rd_val = rf[rf_rd_addr];

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, AD = 2'd2, XR = 2'd3;

    typedef struct {
        logic [1:0] op;
        logic [2:0] addr;
        logic [3:0] data;
        logic [3:0] exp_data;
        logic       exp_carry;
    } vec_t;

    vec_t vecs [20];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issues one command, waits for its response and reports latency
    // (negedges from accept edge to rsp_valid) and write strobes seen.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [3:0] d,
                           output logic [3:0] rd, output logic rc,
                           output int lat, output int nwr);
        int w;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        nwr = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (rf_wr_en) nwr++;
            if (rsp_valid) break;
        end
        rd = rsp_data;
        rc = rsp_carry;
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rd;
        logic       rc;
        int         lat;
        int         nwr;
        int         bad;

        vecs[0]  = '{WR, 3'd5, 4'hA, 4'h0, 1'b0};
        vecs[1]  = '{RD, 3'd5, 4'h0, 4'hA, 1'b0};
        vecs[2]  = '{WR, 3'd5, 4'hA, 4'hA, 1'b0};
        vecs[3]  = '{AD, 3'd5, 4'h9, 4'h3, 1'b1};
        vecs[4]  = '{RD, 3'd5, 4'h0, 4'h3, 1'b0};
        vecs[5]  = '{WR, 3'd2, 4'h6, 4'h0, 1'b0};
        vecs[6]  = '{XR, 3'd2, 4'hF, 4'h9, 1'b0};
        vecs[7]  = '{RD, 3'd2, 4'h0, 4'h9, 1'b0};
        vecs[8]  = '{AD, 3'd3, 4'h4, 4'h4, 1'b0};
        vecs[9]  = '{AD, 3'd7, 4'hF, 4'hF, 1'b0};
        vecs[10] = '{AD, 3'd7, 4'h1, 4'h0, 1'b1};
        vecs[11] = '{WR, 3'd1, 4'h4, 4'h0, 1'b0};
        vecs[12] = '{RD, 3'd0, 4'h0, 4'h0, 1'b0};
        vecs[13] = '{RD, 3'd1, 4'h0, 4'h4, 1'b0};
        vecs[14] = '{RD, 3'd2, 4'h0, 4'h9, 1'b0};
        vecs[15] = '{RD, 3'd3, 4'h0, 4'h4, 1'b0};
        vecs[16] = '{RD, 3'd4, 4'h0, 4'h0, 1'b0};
        vecs[17] = '{RD, 3'd5, 4'h0, 4'h3, 1'b0};
        vecs[18] = '{RD, 3'd6, 4'h0, 4'h0, 1'b0};
        vecs[19] = '{RD, 3'd7, 4'h0, 4'h0, 1'b0};

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_addr    = 3'd0;
        cmd_data    = 4'd0;
        rsp_ready   = 1'b1;
        preload     = 1'b1;
        preload_val = 4'h0;
        repeat (3) @(negedge clk);
        preload = 1'b0;

        chk("reset cmd_ready", cmd_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rf_wr_en", rf_wr_en, 0);
        chk("reset busy", busy, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset rsp_carry", rsp_carry, 0);
        chk("reset rf_rd_addr", rf_rd_addr, 0);

        rst_n = 1'b1;
        #1;
`ifdef RF_SCRUB_EN
        chk("post-reset busy", busy, 1);
`else
        chk("post-reset cmd_ready", cmd_ready, 1);
        chk("post-reset busy", busy, 0);
`endif

        for (int i = 0; i < 20; i++) begin
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, rd, rc, lat, nwr);
            chk($sformatf("v%0d rsp_data", i), rd, vecs[i].exp_data);
            chk($sformatf("v%0d rsp_carry", i), rc, vecs[i].exp_carry);
            chk($sformatf("v%0d latency", i), lat, 2);
            chk($sformatf("v%0d write count", i), nwr, (vecs[i].op == RD) ? 0 : 1);
        end

        // Response back-pressure with a competing command waiting.
        rsp_ready = 1'b0;
        run_cmd(RD, 3'd5, 4'h0, rd, rc, lat, nwr);
        chk("stall rsp_data", rd, 4'h3);
        chk("stall latency", lat, 2);
        cmd_op    = WR;
        cmd_addr  = 3'd6;
        cmd_data  = 4'h7;
        cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== 4'h3 || cmd_ready !== 1'b0 || rf_wr_en !== 1'b0)
                bad++;
        end
        chk("stall hold cycles bad", bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall release rsp_valid", rsp_valid, 0);
        chk("stall release cmd_ready", cmd_ready, 1);
        run_cmd(WR, 3'd6, 4'h7, rd, rc, lat, nwr);
        chk("post-stall write prior", rd, 4'h0);
        chk("post-stall write latency", lat, 2);
        run_cmd(RD, 3'd6, 4'h0, rd, rc, lat, nwr);
        chk("post-stall read", rd, 4'h7);

        // Reset asserted while a WRITE is in EXEC.
        cmd_op    = WR;
        cmd_addr  = 3'd1;
        cmd_data  = 4'hF;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("exec rf_wr_en before reset", rf_wr_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-exec reset rf_wr_en", rf_wr_en, 0);
        chk("mid-exec reset busy", busy, 0);
        chk("mid-exec reset rsp_valid", rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        chk("no rsp after reset", bad, 0);
        run_cmd(RD, 3'd1, 4'h0, rd, rc, lat, nwr);
`ifdef RF_SCRUB_EN
        chk("read after aborted write", rd, 4'h0);
`else
        chk("read after aborted write", rd, 4'h4);
`endif

`ifdef RF_SCRUB_EN
        // Scrub sequence over a fully preloaded RF.
        preload_val = 4'hF;
        preload     = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("scrub%0d cmd_ready", i), cmd_ready, 0);
            chk($sformatf("scrub%0d rf_wr_en", i), rf_wr_en, 1);
            chk($sformatf("scrub%0d rf_wr_addr", i), rf_wr_addr, i);
            chk($sformatf("scrub%0d rf_wr_val", i), rf_wr_val, 0);
            @(negedge clk);
        end
        chk("scrub done cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 8; i++) begin
            run_cmd(RD, 3'(i), 4'h0, rd, rc, lat, nwr);
            chk($sformatf("scrub read %0d", i), rd, 4'h0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
